// File: rtl/wash_pkg.sv
// Shared types and default timing constants for the wash timer block.
package wash_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWashRun,
    StWashDone,
    StSpinRun,
    StSpinDone
  } wash_state_e;

  localparam int unsigned WashCycles = 16;
  localparam int unsigned SpinCycles = 8;
  localparam int unsigned DebCycles  = 4;
  localparam int unsigned CntWidth   = 8;

endpackage

// File: rtl/wash_timer_if.sv
// Controller <-> wash timer signal bundle; master is the machine controller side.
interface wash_timer_if;

  logic door_close;
  logic soap_wash;
  logic water_wash;
  logic motor_on;
  logic drain_value_on;
  logic level_high_raw;
  logic level_low_raw;

  logic filled;
  logic drained;
  logic cycle_timeout;
  logic spin_timeout;
  logic sensor_fault;
  logic busy;

  modport master (
    output door_close, soap_wash, water_wash, motor_on, drain_value_on,
    output level_high_raw, level_low_raw,
    input  filled, drained, cycle_timeout, spin_timeout, sensor_fault, busy
  );

  modport slave (
    input  door_close, soap_wash, water_wash, motor_on, drain_value_on,
    input  level_high_raw, level_low_raw,
    output filled, drained, cycle_timeout, spin_timeout, sensor_fault, busy
  );

endinterface

// File: rtl/level_debounce.sv
// Two-flop synchronizer followed by a debouncer for one asynchronous level sensor.
module level_debounce
  import wash_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DebCycles
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  // Any sample matching the current level restarts the count, so glitches are dropped.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/wash_timer.sv
// Wash/rinse and spin phase timer with debounced tank level sensors.
module wash_timer
  import wash_pkg::*;
#(
  parameter int unsigned WASH_CYCLES = WashCycles,
  parameter int unsigned SPIN_CYCLES = SpinCycles,
  parameter int unsigned DEB_CYCLES  = DebCycles,
  parameter int unsigned CNT_W       = CntWidth
) (
  input logic         clk,
  input logic         reset,
  wash_timer_if.slave bus
);

  logic high_deb, low_deb;

  level_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_high_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.level_high_raw),
    .level (high_deb)
  );

  level_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_low_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.level_low_raw),
    .level (low_deb)
  );

  wash_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       wash_sel_q;
  logic             cycle_timeout_q, spin_timeout_q;

  logic wash_req, spin_req, wash_en, spin_en;
  logic wash_cont, wash_last, spin_last;

  assign wash_req = bus.soap_wash | bus.water_wash;
  assign spin_req = bus.motor_on & bus.drain_value_on;
  assign wash_en  = wash_req & bus.motor_on & bus.door_close;
  assign spin_en  = spin_req & ~wash_req & bus.door_close;

  // A change in which wash input is active forces a trip through idle to restart the count.
  assign wash_cont = wash_req & ({bus.soap_wash, bus.water_wash} == wash_sel_q);
  assign wash_last = wash_en & (cnt_q == CNT_W'(WASH_CYCLES - 1));
  assign spin_last = spin_en & (cnt_q == CNT_W'(SPIN_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      wash_sel_q      <= '0;
      cycle_timeout_q <= 1'b0;
      spin_timeout_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      if (state_q == StIdle) begin
        wash_sel_q <= {bus.soap_wash, bus.water_wash};
      end
      cycle_timeout_q <= (state_d == StWashDone);
      spin_timeout_q  <= (state_d == StSpinDone);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (wash_req) begin
          state_d = StWashRun;
        end else if (spin_req) begin
          state_d = StSpinRun;
        end
      end
      StWashRun: begin
        if (!wash_cont) begin
          state_d = StIdle;
        end else if (wash_last) begin
          state_d = StWashDone;
        end
      end
      StWashDone: begin
        if (!wash_cont) begin
          state_d = StIdle;
        end
      end
      StSpinRun: begin
        if (!spin_req) begin
          state_d = StIdle;
        end else if (spin_last) begin
          state_d = StSpinDone;
        end
      end
      StSpinDone: begin
        if (!spin_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Run states are only entered from idle, so holding the count at zero there clears it on entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if ((state_q == StWashRun && wash_en) || (state_q == StSpinRun && spin_en)) begin
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    bus.busy          = (state_q != StIdle);
    bus.cycle_timeout = cycle_timeout_q;
    bus.spin_timeout  = spin_timeout_q;
    bus.sensor_fault  = high_deb & low_deb;
    bus.filled        = high_deb & ~low_deb;
    bus.drained       = low_deb & ~high_deb;
  end

endmodule

// File: doc/wash_timer.md
WASH_TIMER -- requirements
Module: wash_timer

Interface
REQ-001 Parameter WASH_CYCLES, default 16: enabled clock cycles per wash or rinse phase before cycle_timeout.
REQ-002 Parameter SPIN_CYCLES, default 8: enabled clock cycles of spin before spin_timeout.
REQ-003 Parameter DEB_CYCLES, default 4: consecutive stable synchronized samples required to change a level output.
REQ-004 Parameter CNT_W, default 8: counter width; the parameters SHALL satisfy WASH_CYCLES, SPIN_CYCLES, DEB_CYCLES ≤ 2^CNT_W−1.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 door_close  in  1  1 = door shut; gates all timer counting.
REQ-008 soap_wash, water_wash  in  1 each  wash/rinse phase indications from the machine controller.
REQ-009 motor_on, drain_value_on  in  1 each  motor and drain-valve commands from the machine controller.
REQ-010 level_high_raw, level_low_raw  in  1 each  asynchronous tank sensors: water at full mark, tank empty.
REQ-011 filled, drained  out  1 each  debounced sensor levels fed to the machine controller.
REQ-012 cycle_timeout, spin_timeout  out  1 each  registered phase-expiry levels fed to the machine controller.
REQ-013 sensor_fault  out  1  both debounced sensors asserted at once.
REQ-014 busy  out  1  1 whenever the FSM is not IDLE.

Function
REQ-015 Each raw sensor SHALL pass a 2-flop synchronizer and then a debouncer; the output changes only after DEB_CYCLES consecutive equal synchronized samples that differ from the current output, giving a latency of 2+DEB_CYCLES edges.
REQ-016 A glitch shorter than DEB_CYCLES synchronized samples SHALL restart the debounce count and leave the output unchanged.
REQ-017 If both debounced levels are 1, sensor_fault SHALL be 1 and filled=drained=0 until either level clears.
REQ-018 The FSM states SHALL be IDLE, WASH_RUN, WASH_DONE, SPIN_RUN, SPIN_DONE.
REQ-019 wash_en = (soap_wash|water_wash) & motor_on & door_close.
REQ-020 spin_en = motor_on & drain_value_on & ~soap_wash & ~water_wash & door_close.
REQ-021 IDLE→WASH_RUN when soap_wash|water_wash; IDLE→SPIN_RUN when motor_on & drain_value_on; wash has priority if both hold.
REQ-022 Counters SHALL clear to 0 on entry to a RUN state and increment by 1 only in cycles where the matching enable is 1; otherwise they hold, so a door opening pauses the count.
REQ-023 WASH_RUN→WASH_DONE on the edge where the count equals WASH_CYCLES−1 with wash_en=1; cycle_timeout=1 throughout WASH_DONE.
REQ-024 SPIN_RUN→SPIN_DONE likewise with SPIN_CYCLES−1 and spin_en; spin_timeout=1 throughout SPIN_DONE.
REQ-025 WASH_RUN or WASH_DONE→IDLE when soap_wash=water_wash=0; SPIN_RUN or SPIN_DONE→IDLE when motor_on=0 or drain_value_on=0.
REQ-026 A switch from soap_wash to water_wash with no idle gap SHALL pass through IDLE for one cycle, restarting the count.
REQ-027 Counters SHALL saturate rather than wrap.

Reset
REQ-028 While reset=0: FSM=IDLE; counters, synchronizers and debounce counters=0; filled, drained, cycle_timeout, spin_timeout, sensor_fault and busy=0.
REQ-029 Reset asserted mid-phase SHALL abort the phase immediately; after release, counting restarts from 0.

Structure
REQ-030 Shared package wash_pkg SHALL hold the FSM state enumeration and the default constants WASH_CYCLES, SPIN_CYCLES and DEB_CYCLES.
REQ-031 Sub-module level_debounce (synchronizer plus debouncer, parameter DEB_CYCLES) SHALL be instantiated twice.

Verification
REQ-032 level_high_raw 0→1 held → filled=1 exactly 6 edges later; drained stays 0.
REQ-033 level_high_raw pulses high for 2 cycles → filled stays 0.
REQ-034 soap_wash=motor_on=door_close=1 → cycle_timeout rises 16 enabled cycles after WASH_RUN entry; soap_wash=0 → cycle_timeout=0 and FSM=IDLE next edge.
REQ-035 Wash running, door_close=0 for 5 cycles at count 7 → cycle_timeout arrives 5 cycles late.
REQ-036 motor_on=drain_value_on=1, wash inputs 0 → spin_timeout=1 after 8 cycles; reset=0 at count 4 → all outputs 0 asynchronously.
REQ-037 Both raw sensors held at 1 → sensor_fault=1, filled=drained=0.
